gsu_fetch: RTL and testbench
============================

GSU_FETCH -- requirements
Module: gsu_fetch

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 PC  in  16  GSU program counter (R15), sampled with FETCH_REQ.
REQ-004 PBR  in  8  program bank.
REQ-005 CBR  in  16  cache base; only CBR[15:4] used, CBR[3:0] treated as 0.
REQ-006 FETCH_REQ  in  1  execution stage opcode-byte request; held high until FETCH_ACK.
REQ-007 FETCH_ACK  out  1  one-cycle pulse; FETCH_DATA valid in the same cycle.
REQ-008 FETCH_DATA  out  8  fetched opcode byte.
REQ-009 FLUSH  in  1  one-cycle pulse; invalidates all cache lines (CACHE/LJMP/GO write).
REQ-010 MMIO_CWR  in  1  one-cycle pulse; SNES wrote cache byte MMIO_CADDR.
REQ-011 MMIO_CADDR  in  9  cache offset of that SNES write.
REQ-012 CACHE_ADDR / CACHE_WREN / CACHE_WRDATA  out  9/1/8  cache RAM port A.
REQ-013 CACHE_RDDATA  in  8  cache read data, 1-cycle synchronous latency.
REQ-014 ROM_REQ  out  1  memory request; held high until ROM_ACK.
REQ-015 ROM_ADDR  out  24  memory address; stable while ROM_REQ high.
REQ-016 ROM_ACK  in  1  one-cycle pulse; ROM_DATA valid in the same cycle.
REQ-017 ROM_DATA  in  8  memory read data.

Function
REQ-018 Offset OFS = (PC - {CBR[15:4],4'h0}) mod 2^16; cacheable iff OFS < 512; line = OFS[8:4], byte = OFS[3:0].
REQ-019 32 valid bits, one per 16-byte line.
REQ-020 States: IDLE, LOOKUP, HIT, FILL_REQ, FILL_WR, DIRECT; PC, PBR, CBR latched on leaving IDLE.
REQ-021 IDLE, FETCH_REQ high: cacheable and valid -> LOOKUP (CACHE_ADDR = OFS[8:0]); cacheable and invalid -> FILL_REQ with k = 0; otherwise -> DIRECT.
REQ-022 LOOKUP -> HIT; HIT drives FETCH_DATA = CACHE_RDDATA, pulses FETCH_ACK, -> IDLE; hit latency: FETCH_ACK is high exactly 2 cycles after the edge that samples FETCH_REQ.
REQ-023 FILL_REQ: ROM_REQ = 1, ROM_ADDR = {PBR, ({CBR[15:4],4'h0} + {line,4'h0} + k) mod 2^16}; on ROM_ACK -> FILL_WR.
REQ-024 FILL_WR: CACHE_WREN = 1 for one cycle, CACHE_ADDR = {line,k}, CACHE_WRDATA = the captured ROM_DATA; if k == byte, the byte is also held for FETCH_DATA.
REQ-025 After FILL_WR with k < 15: k increments, -> FILL_REQ.
REQ-026 After FILL_WR with k == 15: valid[line] is set, FETCH_ACK pulses with the held byte, -> IDLE; a fill is always all 16 bytes, in order 0..15.
REQ-027 DIRECT: ROM_REQ with ROM_ADDR = {PBR, PC}; on ROM_ACK, FETCH_DATA = ROM_DATA and FETCH_ACK pulses the next cycle; no cache write, no valid change.
REQ-028 ROM_REQ drops in the cycle after ROM_ACK; never two outstanding ROM requests.
REQ-029 MMIO_CWR with MMIO_CADDR[3:0] == 4'hF sets valid[MMIO_CADDR[8:4]]; other MMIO_CADDR values leave valid bits unchanged.
REQ-030 FLUSH clears all 32 valid bits; FLUSH wins over a simultaneous MMIO_CWR or fill-completion set.
REQ-031 FLUSH during a fill: the fill runs to completion and returns the byte, but valid[line] stays clear.
REQ-032 FETCH_REQ low in IDLE: no ROM or cache activity; CACHE_WREN = 0.
REQ-033 The PC, PBR and CBR latched in REQ-020 are used for the whole access; input changes mid-access are ignored.

Reset
REQ-034 While RST is high: state = IDLE, k = 0, valid = 0.
REQ-035 While RST is high: FETCH_ACK = 0, FETCH_DATA = 0, ROM_REQ = 0, ROM_ADDR = 0, CACHE_WREN = 0, CACHE_ADDR = 0, CACHE_WRDATA = 0.
REQ-036 RST mid-fill or mid-direct aborts the access with no ACK; ROM_REQ is low in the cycle after the RST edge.

Verification
REQ-037 Cold miss: CBR=0x8000, PBR=0x01, PC=0x8023, ROM returns addr[7:0] -> 16 ROM reads 0x018020..0x01802F, cache writes 0x020..0x02F, FETCH_DATA=0x23, valid[2]=1.
REQ-038 Hit: repeat PC=0x8025 after REQ-037 -> no ROM_REQ, FETCH_ACK 2 cycles after request, FETCH_DATA=0x25.
REQ-039 Out of range: CBR=0x8000, PC=0x8200 -> single ROM read 0x018200, no CACHE_WREN, valid unchanged.
REQ-040 MMIO valid: MMIO_CWR at 0x13F -> valid[19]=1; a following PC=CBR+0x130 fetch is a hit.
REQ-041 Flush mid-fill: FLUSH pulse during the k=7 request -> fill completes with ACK, all valid bits 0, next fetch of the same line misses.
REQ-042 Reset mid-fill: RST during k=5 -> ROM_REQ low next cycle, no FETCH_ACK, valid=0.

Source files
------------

// File: rtl/gsu_fetch.sv
// GSU opcode fetch unit: 512-byte instruction cache (32 lines x 16 bytes) in front of
// the ROM/RAM bus, with whole-line fills and uncached direct reads outside the window.
module gsu_fetch (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] PC,
    input  logic [7:0]  PBR,
    input  logic [15:0] CBR,
    input  logic        FETCH_REQ,
    output logic        FETCH_ACK,
    output logic [7:0]  FETCH_DATA,
    input  logic        FLUSH,
    input  logic        MMIO_CWR,
    input  logic [8:0]  MMIO_CADDR,
    output logic [8:0]  CACHE_ADDR,
    output logic        CACHE_WREN,
    output logic [7:0]  CACHE_WRDATA,
    input  logic [7:0]  CACHE_RDDATA,
    output logic        ROM_REQ,
    output logic [23:0] ROM_ADDR,
    input  logic        ROM_ACK,
    input  logic [7:0]  ROM_DATA
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] HIT      = 3'd2;
    localparam logic [2:0] FILL_REQ = 3'd3;
    localparam logic [2:0] FILL_WR  = 3'd4;
    localparam logic [2:0] DIRECT   = 3'd5;

    logic [2:0]  state;
    logic [3:0]  k;
    logic [31:0] valid;
    logic [31:0] valid_next;
    logic [15:0] pc_q;
    logic [7:0]  pbr_q;
    logic [15:0] base_q;
    logic [4:0]  line_q;
    logic [3:0]  byte_q;
    logic [7:0]  rom_data_q;
    logic [7:0]  held_q;
    logic        direct_done;
    logic        fill_flushed;

    logic [15:0] ofs;
    logic        cacheable;
    logic [15:0] fill_ofs;
    logic        fill_done;

    always_comb begin
        ofs       = PC - (CBR & 16'hFFF0);
        cacheable = (ofs[15:9] == 7'd0);
        fill_ofs  = base_q + {7'd0, line_q, 4'h0} + {12'd0, k};
        fill_done = (state == FILL_WR) && (k == 4'hF);
    end

    // A flush seen at any point of a fill keeps that line from being marked valid.
    always_comb begin
        valid_next = valid;
        if (MMIO_CWR && (MMIO_CADDR[3:0] == 4'hF))
            valid_next[MMIO_CADDR[8:4]] = 1'b1;
        if (fill_done && !fill_flushed)
            valid_next[line_q] = 1'b1;
        if (FLUSH)
            valid_next = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            k            <= '0;
            valid        <= '0;
            pc_q         <= '0;
            pbr_q        <= '0;
            base_q       <= '0;
            line_q       <= '0;
            byte_q       <= '0;
            rom_data_q   <= '0;
            held_q       <= '0;
            direct_done  <= 1'b0;
            fill_flushed <= 1'b0;
        end else begin
            valid <= valid_next;
            if (FLUSH && ((state == FILL_REQ) || (state == FILL_WR)))
                fill_flushed <= 1'b1;
            case (state)
                IDLE: begin
                    if (FETCH_REQ) begin
                        pc_q         <= PC;
                        pbr_q        <= PBR;
                        base_q       <= CBR & 16'hFFF0;
                        line_q       <= ofs[8:4];
                        byte_q       <= ofs[3:0];
                        k            <= '0;
                        direct_done  <= 1'b0;
                        fill_flushed <= FLUSH;
                        if (!cacheable)
                            state <= DIRECT;
                        else if (valid[ofs[8:4]])
                            state <= LOOKUP;
                        else
                            state <= FILL_REQ;
                    end
                end
                LOOKUP: state <= HIT;
                HIT:    state <= IDLE;
                FILL_REQ: begin
                    if (ROM_ACK) begin
                        rom_data_q <= ROM_DATA;
                        if (k == byte_q)
                            held_q <= ROM_DATA;
                        state <= FILL_WR;
                    end
                end
                FILL_WR: begin
                    if (k == 4'hF) begin
                        state <= IDLE;
                    end else begin
                        k     <= k + 4'd1;
                        state <= FILL_REQ;
                    end
                end
                DIRECT: begin
                    if (direct_done) begin
                        state <= IDLE;
                    end else if (ROM_ACK) begin
                        held_q      <= ROM_DATA;
                        direct_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Direct reads acknowledge one cycle after ROM_ACK, from the captured byte.
    always_comb begin
        FETCH_ACK    = 1'b0;
        FETCH_DATA   = 8'h00;
        CACHE_ADDR   = 9'h000;
        CACHE_WREN   = 1'b0;
        CACHE_WRDATA = 8'h00;
        ROM_REQ      = 1'b0;
        ROM_ADDR     = 24'h000000;
        case (state)
            LOOKUP: CACHE_ADDR = {line_q, byte_q};
            HIT: begin
                CACHE_ADDR = {line_q, byte_q};
                FETCH_ACK  = 1'b1;
                FETCH_DATA = CACHE_RDDATA;
            end
            FILL_REQ: begin
                ROM_REQ  = 1'b1;
                ROM_ADDR = {pbr_q, fill_ofs};
            end
            FILL_WR: begin
                CACHE_WREN   = 1'b1;
                CACHE_ADDR   = {line_q, k};
                CACHE_WRDATA = rom_data_q;
                if (k == 4'hF) begin
                    FETCH_ACK  = 1'b1;
                    FETCH_DATA = held_q;
                end
            end
            DIRECT: begin
                if (direct_done) begin
                    FETCH_ACK  = 1'b1;
                    FETCH_DATA = held_q;
                end else begin
                    ROM_REQ  = 1'b1;
                    ROM_ADDR = {pbr_q, pc_q};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gsu_fetch.sv
// Scoreboard bench for gsu_fetch: directed fetches push expected ROM reads, cache writes
// and fetch results; one monitor thread pops and compares whenever the DUT presents them.
module tb_gsu_fetch;

    localparam int K_HIT    = 0;
    localparam int K_FILL   = 1;
    localparam int K_DIRECT = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] PC;
    logic [7:0]  PBR;
    logic [15:0] CBR;
    logic        FETCH_REQ;
    logic        FETCH_ACK;
    logic [7:0]  FETCH_DATA;
    logic        FLUSH;
    logic        MMIO_CWR;
    logic [8:0]  MMIO_CADDR;
    logic [8:0]  CACHE_ADDR;
    logic        CACHE_WREN;
    logic [7:0]  CACHE_WRDATA;
    logic [7:0]  CACHE_RDDATA;
    logic        ROM_REQ;
    logic [23:0] ROM_ADDR;
    logic        ROM_ACK;
    logic [7:0]  ROM_DATA;

    logic [7:0]  snes_data;
    logic [7:0]  mem [0:511];
    int          cyc = 0;
    logic        rst_seen = 1'b0;
    int          rom_wait = 0;

    typedef struct {
        logic [7:0] data;
        bit         chk_lat;
        int         req_cyc;
    } fetch_exp_t;

    fetch_exp_t  fetch_q[$];
    logic [23:0] rom_q[$];
    logic [16:0] wr_q[$];

    int checks = 0;
    int fails  = 0;

    gsu_fetch dut (
        .CLK(CLK), .RST(RST), .PC(PC), .PBR(PBR), .CBR(CBR),
        .FETCH_REQ(FETCH_REQ), .FETCH_ACK(FETCH_ACK), .FETCH_DATA(FETCH_DATA),
        .FLUSH(FLUSH), .MMIO_CWR(MMIO_CWR), .MMIO_CADDR(MMIO_CADDR),
        .CACHE_ADDR(CACHE_ADDR), .CACHE_WREN(CACHE_WREN), .CACHE_WRDATA(CACHE_WRDATA),
        .CACHE_RDDATA(CACHE_RDDATA), .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR),
        .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= RST;
    end

    // Cache RAM with one-cycle read latency; the SNES side writes through MMIO_CWR.
    always @(posedge CLK) begin
        if (CACHE_WREN)
            mem[CACHE_ADDR] <= CACHE_WRDATA;
        else if (MMIO_CWR)
            mem[MMIO_CADDR] <= snes_data;
        CACHE_RDDATA <= mem[CACHE_ADDR];
    end

    // ROM answers in the second cycle of a request with the low address byte.
    initial begin
        ROM_ACK  = 1'b0;
        ROM_DATA = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            ROM_ACK = 1'b0;
            if (ROM_REQ) begin
                rom_wait++;
                if (rom_wait >= 2) begin
                    ROM_ACK  = 1'b1;
                    ROM_DATA = ROM_ADDR[7:0];
                    rom_wait = 0;
                end
            end else begin
                rom_wait = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no $finish by 500000, expected earlier end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        fails++;
        $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
    endtask

    task automatic run_monitor();
        fetch_exp_t  e;
        logic [23:0] ra;
        logic [16:0] w;
        bit          ack_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (rst_seen) begin
                check("reset FETCH_ACK", {31'd0, FETCH_ACK}, 32'd0);
                check("reset FETCH_DATA", {24'd0, FETCH_DATA}, 32'd0);
                check("reset ROM_REQ", {31'd0, ROM_REQ}, 32'd0);
                check("reset ROM_ADDR", {8'd0, ROM_ADDR}, 32'd0);
                check("reset CACHE_WREN", {31'd0, CACHE_WREN}, 32'd0);
                check("reset CACHE_ADDR", {23'd0, CACHE_ADDR}, 32'd0);
                check("reset CACHE_WRDATA", {24'd0, CACHE_WRDATA}, 32'd0);
                ack_prev = 1'b0;
            end else begin
                if (ack_prev)
                    check("ROM_REQ after ROM_ACK", {31'd0, ROM_REQ}, 32'd0);
                ack_prev = ROM_REQ && ROM_ACK;
                if (ROM_REQ && ROM_ACK) begin
                    if (rom_q.size() == 0) begin
                        unexpected("ROM read", {8'd0, ROM_ADDR});
                    end else begin
                        ra = rom_q.pop_front();
                        check("ROM_ADDR", {8'd0, ROM_ADDR}, {8'd0, ra});
                    end
                end
                if (CACHE_WREN) begin
                    if (wr_q.size() == 0) begin
                        unexpected("cache write", {15'd0, CACHE_ADDR, CACHE_WRDATA});
                    end else begin
                        w = wr_q.pop_front();
                        check("cache write addr/data", {15'd0, CACHE_ADDR, CACHE_WRDATA}, {15'd0, w});
                    end
                end
                if (FETCH_ACK) begin
                    if (fetch_q.size() == 0) begin
                        unexpected("FETCH_ACK", {24'd0, FETCH_DATA});
                    end else begin
                        e = fetch_q.pop_front();
                        check("FETCH_DATA", {24'd0, FETCH_DATA}, {24'd0, e.data});
                        // Edges from the one sampling FETCH_REQ to the one capturing FETCH_ACK.
                        if (e.chk_lat)
                            check("hit latency", cyc + 1 - e.req_cyc, 32'd2);
                    end
                end
            end
        end
    endtask

    task automatic push_fill(input logic [23:0] rom_base, input logic [8:0] line_addr, input int count);
        logic [23:0] a;
        logic [8:0]  c;
        for (int i = 0; i < count; i++) begin
            a = rom_base + 24'(i);
            c = line_addr + 9'(i);
            rom_q.push_back(a);
            wr_q.push_back({c, a[7:0]});
        end
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [7:0] pbr, input logic [15:0] cbr,
                         input int kind, input logic [23:0] rom_base, input logic [8:0] line_addr,
                         input logic [7:0] exp_data);
        fetch_exp_t e;
        int n;
        @(posedge CLK);
        #1;
        if (kind == K_FILL)
            push_fill(rom_base, line_addr, 16);
        else if (kind == K_DIRECT)
            rom_q.push_back(rom_base);
        e.data    = exp_data;
        e.chk_lat = (kind == K_HIT);
        e.req_cyc = cyc + 1;
        fetch_q.push_back(e);
        PC        = pc;
        PBR       = pbr;
        CBR       = cbr;
        FETCH_REQ = 1'b1;
        @(posedge CLK);
        #1;
        PC  = 16'hDEAD;
        PBR = 8'hEE;
        CBR = 16'h1234;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!FETCH_ACK && n < 200);
        if (!FETCH_ACK)
            unexpected("FETCH_ACK timeout for PC", {16'd0, pc});
        @(posedge CLK);
        #1;
        FETCH_REQ = 1'b0;
    endtask

    task automatic wait_rom_nibble(input logic [3:0] nib);
        int n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!(ROM_REQ && ROM_ADDR[3:0] == nib) && n < 300);
        if (!(ROM_REQ && ROM_ADDR[3:0] == nib))
            unexpected("timeout waiting for ROM nibble", {28'd0, nib});
    endtask

    task automatic snes_write(input logic [8:0] addr, input logic [7:0] data, input logic flush);
        @(posedge CLK);
        #1;
        MMIO_CWR   = 1'b1;
        MMIO_CADDR = addr;
        snes_data  = data;
        FLUSH      = flush;
        @(posedge CLK);
        #1;
        MMIO_CWR = 1'b0;
        FLUSH    = 1'b0;
    endtask

    task automatic run_stimulus();
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);

        // Cold miss, hit, out-of-window reads on both sides, last byte of the window.
        fetch(16'h8023, 8'h01, 16'h8000, K_FILL,   24'h018020, 9'h020, 8'h23);
        fetch(16'h8025, 8'h01, 16'h8000, K_HIT,    24'h0,      9'h0,   8'h25);
        fetch(16'h8200, 8'h01, 16'h8000, K_DIRECT, 24'h018200, 9'h0,   8'h00);
        fetch(16'h7FFF, 8'h01, 16'h8000, K_DIRECT, 24'h017FFF, 9'h0,   8'hFF);
        fetch(16'h8023, 8'h01, 16'h8000, K_HIT,    24'h0,      9'h0,   8'h23);
        fetch(16'h81FF, 8'h01, 16'h8000, K_FILL,   24'h0181F0, 9'h1F0, 8'hFF);
        fetch(16'h81F0, 8'h01, 16'h8000, K_HIT,    24'h0,      9'h0,   8'hF0);

        // Only a write to byte 15 of a line validates it.
        snes_write(9'h150, 8'h77, 1'b0);
        snes_write(9'h130, 8'h5A, 1'b0);
        snes_write(9'h13F, 8'h3F, 1'b0);
        fetch(16'h8130, 8'h01, 16'h8000, K_HIT,    24'h0,      9'h0,   8'h5A);
        fetch(16'h8150, 8'h01, 16'h8000, K_FILL,   24'h018150, 9'h150, 8'h50);

        // Flush during the k=7 request of a fill.
        fork
            fetch(16'h8047, 8'h01, 16'h8000, K_FILL, 24'h018040, 9'h040, 8'h47);
            begin
                wait_rom_nibble(4'h7);
                FLUSH = 1'b1;
                @(posedge CLK);
                #1;
                FLUSH = 1'b0;
            end
        join
        fetch(16'h8047, 8'h01, 16'h8000, K_FILL, 24'h018040, 9'h040, 8'h47);
        fetch(16'h8023, 8'h01, 16'h8000, K_FILL, 24'h018020, 9'h020, 8'h23);

        // Reset during the k=5 request: bytes 0..4 were already read and written.
        @(posedge CLK);
        #1;
        push_fill(24'h018060, 9'h060, 5);
        PC        = 16'h8065;
        PBR       = 8'h01;
        CBR       = 16'h8000;
        FETCH_REQ = 1'b1;
        wait_rom_nibble(4'h5);
        RST       = 1'b1;
        FETCH_REQ = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        fetch(16'h8023, 8'h01, 16'h8000, K_FILL, 24'h018020, 9'h020, 8'h23);

        // Flush beats a simultaneous byte-15 MMIO write.
        snes_write(9'h13F, 8'h3F, 1'b1);
        fetch(16'h8130, 8'h01, 16'h8000, K_FILL, 24'h018130, 9'h130, 8'h30);

        // Window base near the top of the bank wraps the fill address to 0x0000.
        fetch(16'h0005, 8'h7E, 16'hFFF5, K_FILL, 24'h7E0000, 9'h010, 8'h05);
        fetch(16'h000F, 8'h7E, 16'hFFF5, K_HIT,  24'h0,      9'h0,   8'h0F);

        repeat (5) @(posedge CLK);
        check("fetch queue drained", fetch_q.size(), 32'd0);
        check("ROM queue drained", rom_q.size(), 32'd0);
        check("cache write queue drained", wr_q.size(), 32'd0);
    endtask

    initial begin
        RST        = 1'b1;
        PC         = 16'h0000;
        PBR        = 8'h00;
        CBR        = 16'h0000;
        FETCH_REQ  = 1'b0;
        FLUSH      = 1'b0;
        MMIO_CWR   = 1'b0;
        MMIO_CADDR = 9'h000;
        snes_data  = 8'h00;
        fork
            run_monitor();
            begin
                run_stimulus();
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        join
    end

endmodule
